// File: rtl/byte_serializer_pkg.sv
// Shared constants, state encoding and helpers for the byte serializer.
package byte_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam logic        IDLE_LEVEL_DEFAULT = 1'b0;
  localparam int unsigned BUF_DEPTH          = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a bit index into a WIDTH-bit word (at least one bit).
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Load handshake and serial output bundle of the byte serializer.
interface byte_serializer_if #(
  parameter int unsigned WIDTH = byte_serializer_pkg::DEFAULT_WIDTH
);
  import byte_serializer_pkg::*;

  localparam int unsigned IDX_W = idx_width(WIDTH);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             data_out;
  logic             out_valid;
  logic [IDX_W-1:0] bit_index;

  modport master (
    output load_data, load_valid,
    input  load_ready, data_out, out_valid, bit_index
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, data_out, out_valid, bit_index
  );

endinterface

// File: rtl/serializer_buffer.sv
// Two-entry in-order holding buffer; full/empty are registered flags.
module serializer_buffer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Push and pop together leave occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CNT_W'(BUF_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter: buffers up to two words and shifts them out MSB first.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  byte_serializer_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic             buf_full, buf_empty;
  logic [WIDTH-1:0] head_data;
  logic             push_c, pop_c, load_next_c;

  assign push_c = bus.load_valid && !buf_full;

  serializer_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (bus.load_data),
    .pop       (pop_c),
    .pop_data  (head_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Next word is taken when idle or on the last bit of the current word.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    pop_c       = 1'b0;
    load_next_c = !buf_empty && ((state_q == ST_IDLE) || (idx_q == '0));

    if (load_next_c) begin
      pop_c   = 1'b1;
      shift_d = head_data;
      idx_d   = IDX_W'(WIDTH - 1);
      valid_d = 1'b1;
      state_d = ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (idx_q == '0) begin
            state_d = ST_IDLE;
            shift_d = {WIDTH{IDLE_LEVEL}};
            idx_d   = '0;
            valid_d = 1'b0;
          end else begin
            shift_d = {shift_q[WIDTH-2:0], IDLE_LEVEL};
            idx_d   = idx_q - IDX_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= {WIDTH{IDLE_LEVEL}};
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out   = shift_q[WIDTH-1];
  assign bus.out_valid  = valid_q;
  assign bus.bit_index  = idx_q;
  assign bus.load_ready = !buf_full;

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per parallel word.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0: level driven on data_out when no word is being shifted.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port load_data, input, WIDTH: parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1: load_data holds a word.
REQ-007 SHALL have port load_ready, output, 1: block can accept a word this cycle.
REQ-008 SHALL have port data_out, output, 1: serial bit stream, one bit per clk, for the downstream sequence detector's data_in.
REQ-009 SHALL have port out_valid, output, 1: data_out carries a word bit, not idle fill.
REQ-010 SHALL have port bit_index, output, log2(WIDTH): index of the bit currently on data_out; 0 when idle.

Function
REQ-011 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; load_data is ignored otherwise.
REQ-012 Accepted words SHALL enter a 2-entry in-order holding buffer; load_ready = buffer occupancy < 2, registered.
REQ-013 Simultaneous accept and pop on one edge SHALL leave occupancy unchanged and preserve order.
REQ-014 State machine: IDLE (shift register empty), SHIFT (word in shift register).
REQ-015 IDLE -> SHIFT on the edge after which the buffer is non-empty; that edge pops the head word into the shift register.
REQ-016 Latency: word accepted at edge N into an empty block SHALL put its MSB on data_out after edge N+1.
REQ-017 In SHIFT, data_out SHALL present the word MSB first, one bit per cycle, WIDTH cycles per word; bit_index counts WIDTH-1 down to 0.
REQ-018 On the edge ending bit_index 0: buffer non-empty -> pop next word, its MSB follows with no gap cycle; buffer empty -> IDLE.
REQ-019 In IDLE, data_out = IDLE_LEVEL, out_valid = 0, bit_index = 0.
REQ-020 data_out, out_valid and bit_index SHALL be register outputs (no combinational path from load_* ports).
REQ-021 load_valid deasserted mid-word SHALL NOT disturb the word being shifted.

Reset
REQ-022 reset asserted SHALL immediately force: state IDLE, buffer empty, data_out = IDLE_LEVEL, out_valid = 0, bit_index = 0, load_ready = 1.
REQ-023 reset mid-word SHALL discard the partial word and all buffered words; no bits of them appear after release.
REQ-024 First word SHALL be acceptable on the first rising edge after reset deasserts.

Structure
REQ-025 Shared package SHALL hold the state encoding (IDLE, SHIFT), the IDLE_LEVEL default and the buffer depth constant (2).
REQ-026 The 2-entry holding buffer SHALL be a sub-module, serializer_buffer (push/pop/full/empty, asynchronous reset).
REQ-027 Shift register, bit counter and state machine SHALL reside in byte_serializer.

Verification
REQ-028 Single word: accept 8'b1010_1100 at edge N -> data_out 1,0,1,0,1,1,0,0 after edges N+1..N+8, out_valid high exactly those 8 cycles; detector downstream reports match.
REQ-029 Back-to-back: load_valid held with 8'hA5, 8'h3C, 8'hFF -> 24 contiguous out_valid cycles, bits 10100101 00111100 11111111, no gap.
REQ-030 Backpressure: 4 words offered while first shifts -> load_ready low after 2 buffered; 4th word accepted only once a pop frees an entry; all 4 emitted in order.
REQ-031 Simultaneous push/pop at a word boundary with one entry buffered -> occupancy stays 1, load_ready stays 1, order preserved.
REQ-032 Reset asserted at bit_index 4 with one word buffered -> data_out = 0, out_valid = 0 immediately; after release no stale bits, next accepted 8'h81 emits 1,0,0,0,0,0,0,1.
REQ-033 Idle: no load_valid for 20 cycles after reset -> data_out = IDLE_LEVEL, out_valid = 0, load_ready = 1 throughout.
